// File: rtl/vote_ctrl.sv
// Session controller for the three-voter majority datapath: collects one ballot
// per voter, then registers the majority result and tallies and holds them with done.
module vote_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int HOLD    = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [2:0] i_vote_valid,
  input  logic [2:0] i_vote_bit,
  output logic [2:0] o_vote_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_result,
  output logic [1:0] o_yes_cnt,
  output logic [1:0] o_no_cnt,
  output logic [2:0] o_missing,
  output logic [3:0] o_session_cnt,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DECIDE  = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     r_state;
  logic [2:0] r_cast;
  logic [2:0] r_ballot;
  logic [7:0] r_timer;
  logic       r_result;
  logic [1:0] r_yes_cnt;
  logic [1:0] r_no_cnt;
  logic [2:0] r_missing;
  logic [3:0] r_session_cnt;

  logic [2:0] w_take;
  logic [2:0] w_cast_next;
  logic [2:0] w_ballot_next;
  logic [2:0] w_yes;
  logic [2:0] w_no;
  logic [1:0] w_yes_cnt;
  logic [1:0] w_no_cnt;

  // Handshake: voter i transfers on an edge where vote_valid[i] and vote_ready[i]
  // are both high; ready depends only on registered state, never on valid.
  assign w_take        = i_vote_valid & ~r_cast;
  assign w_cast_next   = r_cast | w_take;
  assign w_ballot_next = (r_ballot & ~w_take) | (i_vote_bit & w_take);

  // A voter that never cast is neither yes nor no, so it counts against the motion.
  assign w_yes     = r_ballot & r_cast;
  assign w_no      = ~r_ballot & r_cast;
  assign w_yes_cnt = {1'b0, w_yes[0]} + {1'b0, w_yes[1]} + {1'b0, w_yes[2]};
  assign w_no_cnt  = {1'b0, w_no[0]} + {1'b0, w_no[1]} + {1'b0, w_no[2]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cast        <= 3'b000;
      r_ballot      <= 3'b000;
      r_timer       <= 8'd0;
      r_result      <= 1'b0;
      r_yes_cnt     <= 2'd0;
      r_no_cnt      <= 2'd0;
      r_missing     <= 3'b000;
      r_session_cnt <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_COLLECT;
            r_cast    <= 3'b000;
            r_ballot  <= 3'b000;
            r_timer   <= 8'd0;
            r_result  <= 1'b0;
            r_yes_cnt <= 2'd0;
            r_no_cnt  <= 2'd0;
            r_missing <= 3'b000;
          end
        end
        S_COLLECT: begin
          r_cast   <= w_cast_next;
          r_ballot <= w_ballot_next;
          r_timer  <= r_timer + 8'd1;
          if ((&w_cast_next) || (r_timer == TMO_LAST)) begin
            r_state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          r_result      <= (w_yes[0] & w_yes[1]) | (w_yes[1] & w_yes[2]) | (w_yes[0] & w_yes[2]);
          r_yes_cnt     <= w_yes_cnt;
          r_no_cnt      <= w_no_cnt;
          r_missing     <= ~r_cast;
          r_session_cnt <= r_session_cnt + 4'd1;
          r_timer       <= 8'd0;
          r_state       <= S_HOLD;
        end
        S_HOLD: begin
          if (r_timer == HOLD_LAST) begin
            r_timer <= 8'd0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_vote_ready  = (r_state == S_COLLECT) ? ~r_cast : 3'b000;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_HOLD);
  assign o_result      = r_result;
  assign o_yes_cnt     = r_yes_cnt;
  assign o_no_cnt      = r_no_cnt;
  assign o_missing     = r_missing;
  assign o_session_cnt = r_session_cnt;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_vote_ctrl.sv
// Bench for vote_ctrl: per-session ballot schedules are turned into expected
// per-cycle outputs with a transaction-level model of the voting rules.
module tb_vote_ctrl;
  localparam int TIMEOUT = 16;
  localparam int HOLD    = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] vote_valid;
  logic [2:0] vote_bit;
  logic [2:0] vote_ready;
  logic       busy;
  logic       done;
  logic       result;
  logic [1:0] yes_cnt;
  logic [1:0] no_cnt;
  logic [2:0] missing;
  logic [3:0] session_cnt;
  logic [1:0] dbg_state;

  vote_ctrl #(.TIMEOUT(TIMEOUT), .HOLD(HOLD)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_vote_valid(vote_valid), .i_vote_bit(vote_bit),
    .o_vote_ready(vote_ready), .o_busy(busy), .o_done(done),
    .o_result(result), .o_yes_cnt(yes_cnt), .o_no_cnt(no_cnt),
    .o_missing(missing), .o_session_cnt(session_cnt), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: {result, yes_cnt, no_cnt, missing}
  logic [7:0] exp_q[$];
  logic [7:0] last_res;
  int         sess;
  int         sched_edge[3];
  bit         sched_bit[3];
  bit         armed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic check_cycle(input string tag, input logic eb, input logic ed,
                             input logic [2:0] er, input logic [7:0] eres, input int es);
    check({tag, "_busy"}, 32'(busy), 32'(eb));
    check({tag, "_done"}, 32'(done), 32'(ed));
    check({tag, "_ready"}, 32'(vote_ready), 32'(er));
    check({tag, "_res"}, 32'({result, yes_cnt, no_cnt, missing}), 32'(eres));
    check({tag, "_sess"}, 32'(session_cnt), 32'(es));
  endtask

  task automatic set_sched(input int e0, input bit b0, input int e1, input bit b1,
                           input int e2, input bit b2);
    sched_edge[0] = e0; sched_bit[0] = b0;
    sched_edge[1] = e1; sched_bit[1] = b1;
    sched_edge[2] = e2; sched_bit[2] = b2;
  endtask

  task automatic rand_sched();
    for (int i = 0; i < 3; i++) begin
      sched_edge[i] = int'($urandom_range(0, 20));
      sched_bit[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  // driver: start must already be high for edge 0 when this is called
  task automatic run_session(input bit next_start);
    bit         all_in;
    bit         acc[3];
    int         mx, close, last, yes, no;
    logic [2:0] miss, er;
    logic [7:0] exp_res, exp_cur;
    all_in = 1; mx = 0; yes = 0; no = 0; miss = 3'b000; exp_cur = 8'h00;
    for (int i = 0; i < 3; i++) begin
      if (sched_edge[i] == 0 || sched_edge[i] > TIMEOUT) all_in = 0;
      if (sched_edge[i] > mx) mx = sched_edge[i];
    end
    close = all_in ? mx : TIMEOUT;
    for (int i = 0; i < 3; i++) begin
      acc[i] = (sched_edge[i] != 0) && (sched_edge[i] <= close);
      if (acc[i] && sched_bit[i]) yes++;
      if (acc[i] && !sched_bit[i]) no++;
      miss[i] = !acc[i];
    end
    exp_res = {(yes >= 2) ? 1'b1 : 1'b0, 2'(yes), 2'(no), miss};
    exp_q.push_back(exp_res);
    last = close + 2 + HOLD;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      if (c <= close) begin
        for (int i = 0; i < 3; i++) er[i] = !(acc[i] && sched_edge[i] < c);
        check_cycle("collect", 1'b1, 1'b0, er, 8'h00, sess);
      end else if (c == close + 1) begin
        check_cycle("decide", 1'b1, 1'b0, 3'b000, 8'h00, sess);
      end else if (c < last) begin
        if (c == close + 2) begin
          exp_cur = exp_q.pop_front();
          sess = (sess + 1) % 16;
        end
        check_cycle("hold", 1'b1, 1'b1, 3'b000, exp_cur, sess);
      end else begin
        last_res = exp_cur;
        check_cycle("idle", 1'b0, 1'b0, 3'b000, last_res, sess);
      end
      start = (c == last) ? next_start : 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) begin
        if (c <= close) begin
          vote_valid[i] = (c == sched_edge[i]) ||
                          (sched_edge[i] != 0 && c > sched_edge[i] && $urandom_range(0, 1) == 1);
          vote_bit[i]   = (c == sched_edge[i]) ? sched_bit[i] : 1'($urandom_range(0, 1));
        end else begin
          vote_valid[i] = 1'($urandom_range(0, 1));
          vote_bit[i]   = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic idle_then_start();
    @(posedge clk); #1;
    check_cycle("idle_gap", 1'b0, 1'b0, 3'b000, last_res, sess);
    start = 1'b1;
    vote_valid = 3'($urandom_range(0, 7));
    vote_bit   = 3'($urandom_range(0, 7));
  endtask

  // start must already be high for edge 0; reset is applied at edge n
  task automatic abort_run(input int n, input bit noisy);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (c == n) check("abort_busy", 32'(busy), 32'd1);
      start      = 1'($urandom_range(0, 1));
      vote_valid = noisy ? 3'($urandom_range(0, 7)) : 3'b000;
      vote_bit   = 3'($urandom_range(0, 7));
      if (c == n) reset = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; vote_valid = 3'b000;
    sess = 0; last_res = 8'h00; exp_q.delete();
    check_cycle("abort", 1'b0, 1'b0, 3'b000, 8'h00, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vote_valid = 3'b000; vote_bit = 3'b000;
    sess = 0; last_res = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_cycle("reset", 1'b0, 1'b0, 3'b000, 8'h00, 0);
    reset = 1'b0; start = 1'b1;

    set_sched(1, 1'b1, 1, 1'b0, 1, 1'b1);   // minimum session
    run_session(1'b0);
    idle_then_start();
    set_sched(5, 1'b0, 7, 1'b1, 2, 1'b0);   // staggered, repeat from voter 0
    run_session(1'b0);
    idle_then_start();
    set_sched(0, 1'b0, 3, 1'b1, 0, 1'b0);   // timeout with one ballot
    run_session(1'b0);
    idle_then_start();
    set_sched(2, 1'b1, 4, 1'b1, TIMEOUT, 1'b1);  // ballot on the last COLLECT edge
    run_session(1'b0);

    idle_then_start();
    abort_run(5, 1'b0);
    idle_then_start();
    set_sched(3, 1'b0, 1, 1'b1, 2, 1'b1);
    run_session(1'b0);

    // reset and start on the same edge
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check_cycle("rst_start", 1'b0, 1'b0, 3'b000, 8'h00, 0);
    @(posedge clk); #1;
    check("rst_start_idle", 32'(busy), 32'd0);
    sess = 0; last_res = 8'h00;

    // sixteen back-to-back sessions: session_cnt wraps
    start = 1'b1;
    for (int k = 0; k < 17; k++) begin
      rand_sched();
      run_session(k < 16);
    end
    armed = 1'b0;

    for (int k = 0; k < 24; k++) begin
      if (!armed) idle_then_start();
      rand_sched();
      if (k % 6 == 5) begin
        abort_run(int'($urandom_range(1, 10)), 1'b1);
        armed = 1'b0;
      end else begin
        armed = 1'($urandom_range(0, 1));
        run_session(armed);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vote_ctrl.md
# vote_ctrl

Session controller for the three-voter majority datapath. It opens a voting session on `start` and collects one ballot per voter through valid/ready handshakes, closing on all-cast or timeout. It then registers the majority result with yes/no tallies and holds them with `done` for a fixed number of cycles. A 4-bit session counter is exported for the seven-segment display decoder.

## Interface

Parameters:
- `TIMEOUT`, default 16: maximum number of cycles spent in COLLECT; legal range 1..255.
- `HOLD`, default 8: number of cycles `done` stays high; legal range 1..255.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; dominates all other inputs.
- `start` in 1: session request; sampled only in IDLE.
- `vote_valid` in 3: per-voter ballot valid; bit i belongs to voter i.
- `vote_bit` in 3: per-voter ballot; 1 = yes, 0 = no.
- `vote_ready` out 3: per-voter ready.
- `busy` out 1: high in COLLECT, DECIDE and HOLD.
- `done` out 1: high only in HOLD.
- `result` out 1: majority decision.
- `yes_cnt` out 2: number of yes ballots cast.
- `no_cnt` out 2: number of no ballots cast.
- `missing` out 3: voters that did not cast; bit i belongs to voter i.
- `session_cnt` out 4: completed sessions, modulo 16.

## Operation

- Reset, synchronous and active-high: state IDLE. All outputs 0, `session_cnt` 0, internal `cast`/`ballot` registers 0, timer 0.
- IDLE:
  - `vote_ready`, `busy` and `done` are all 0.
  - `start`=1 moves to COLLECT and clears `cast`, `ballot`, the timer, `result`, `yes_cnt`, `no_cnt` and `missing`.
  - `result`, `yes_cnt`, `no_cnt` and `missing` otherwise retain the previous session's values.
- COLLECT:
  - `vote_ready[i]` = ~`cast[i]`, decoded from registers only, with no input-to-output path.
  - Handshake: `vote_valid[i]` & `vote_ready[i]` at an edge latches `ballot[i]`=`vote_bit[i]` and sets `cast[i]`.
  - A voter gets one ballot per session; further valids from that voter are ignored.
  - Any subset of voters may hand off on the same edge.
  - The timer increments on every COLLECT edge.
  - Exit to DECIDE on the edge where all three `cast` bits are set, counting ballots accepted on that same edge.
  - Exit to DECIDE on the edge where the timer reaches `TIMEOUT`-1. A ballot handed off on that edge is still accepted.
  - `start` is ignored.
- DECIDE, one cycle:
  - Register `result` = (b0&b1)|(b1&b2)|(b0&b2), where bi = `ballot[i]` & `cast[i]`; a missing voter counts as no.
  - `yes_cnt` = popcount(`ballot` & `cast`).
  - `no_cnt` = popcount(~`ballot` & `cast`).
  - `missing` = ~`cast`.
  - Go to HOLD.
- HOLD:
  - `done`=1 for exactly `HOLD` cycles; outputs stable.
  - `session_cnt` increments once, on the DECIDE→HOLD edge, wrapping 15→0.
  - Return to IDLE; `start` is ignored throughout HOLD.
- Invariant: `yes_cnt` + `no_cnt` + popcount(`missing`) = 3 whenever `done`=1.

## Timing

- Edge numbering: `start` sampled at edge 0 (state IDLE) puts COLLECT in cycle 1, with `vote_ready`=3'b111 and `busy`=1 in cycle 1.
- Last ballot accepted at edge k puts DECIDE in cycle k+1. HOLD (`done`=1 with valid results) then occupies cycles k+2 .. k+1+`HOLD`, and IDLE resumes at cycle k+2+`HOLD`.
- Minimum session, all three ballots at edge 1 (first COLLECT edge): `done` rises in cycle 3.
- Timeout: COLLECT occupies at most `TIMEOUT` cycles (cycles 1..`TIMEOUT`), so DECIDE is in cycle `TIMEOUT`+1.
- `vote_ready[i]` drops in the cycle after voter i's handshake edge.
- Back-to-back sessions: `start` held high re-enters COLLECT at the first IDLE edge. There is one IDLE cycle between sessions.
- `reset` at any edge, including mid-COLLECT or mid-HOLD, forces the reset values at that edge.
  - No `done` pulse and no `session_cnt` increment for the aborted session.
  - `reset` and `start` high on the same edge: reset wins and the state stays IDLE.

## Test plan

- Reset, then `start` at edge 0, with voters 0/1/2 valid at edge 1 carrying bits 1/0/1 → `done` in cycles 3..10, `result`=1, `yes_cnt`=2, `no_cnt`=1, `missing`=000, `session_cnt`=1.
- Staggered ballots, voter 2 at edge 2 with 0, voter 0 at edge 5 with 0 and a repeated valid with 1 at edge 6, voter 1 at edge 7 with 1 → `vote_ready[0]` low from cycle 6, `result`=0, `yes_cnt`=1, `no_cnt`=2.
- Timeout with `TIMEOUT`=16: only voter 1 votes 1, at edge 3 → DECIDE in cycle 17, `result`=0, `missing`=101, `yes_cnt`=1, `no_cnt`=0.
- Last-edge acceptance: voters 0 and 1 vote 1 early and voter 2 votes 1 exactly at edge 16 → accepted, `missing`=000, `yes_cnt`=3.
- `reset` asserted in cycle 5 of COLLECT → next cycle all outputs 0, `session_cnt` unchanged at 0, and the following `start` runs a clean session.
- Sixteen consecutive sessions with `start` held high → `session_cnt` wraps 15→0, with exactly one IDLE cycle between `done` windows.
